matrix_bank_manager: RTL and testbench
======================================

# matrix_bank_manager

Slot-organised matrix store that supersedes the single-reader storage manager: one single-port BRAM holding NUM_SLOTS matrix blocks, an integrated header/data write engine, and NUM_READERS round-robin-arbitrated read ports. It also adds input validation, a per-slot valid bitmap and slot invalidation. It sits between the matrix input/generator path and the compute and display units that fetch operands.

## Interface
- DATA_WIDTH, 32: word width; must be ≥ 32 because the name is packed 4 bytes/word.
- ADDR_WIDTH, 14: BRAM address width.
- BLOCK_SIZE, 1152: words per slot, including the 3 header words.
- NUM_SLOTS, 8: matrix slots; NUM_SLOTS*BLOCK_SIZE ≤ 2^ADDR_WIDTH.
- NUM_READERS, 2: read requesters, ≥ 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- write_request  in  1  starts a write when write_ready=1.
- write_ready  out  1  high in IDLE.
- matrix_id  in  $clog2(NUM_SLOTS)  target slot; sampled on accept.
- actual_rows, actual_cols  in  8 each  dimensions; sampled on accept.
- matrix_name  in  8×8 unpacked [0:7]  ASCII name; sampled on accept.
- data_in  in  DATA_WIDTH  element, row-major.
- data_valid  in  1  element strobe; honoured only while writer_ready=1.
- writer_ready  out  1  high in DATA state.
- write_done  out  1  one-cycle pulse on completion.
- write_error  out  1  one-cycle pulse on rejected request.
- clear_req  in  1  invalidates slot clear_id.
- clear_id  in  $clog2(NUM_SLOTS)  slot to invalidate.
- slot_valid  out  NUM_SLOTS  bit i = slot i holds a complete matrix.
- rd_req  in  NUM_READERS  per-reader request; held until granted.
- rd_addr  in  NUM_READERS*ADDR_WIDTH  flat; reader i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_grant  out  NUM_READERS  combinational one-hot grant.
- rd_valid  out  NUM_READERS  one-hot, registered; rd_data valid for that reader.
- rd_data  out  DATA_WIDTH  shared read data.

## Operation
- Slot layout: base = id*BLOCK_SIZE. base+0 = {zeros, rows, cols}; base+1 = {name[0],name[1],name[2],name[3]}, name[0] in MSB; base+2 = name[4..7]; elements at base+3 .. base+2+rows*cols.
- Write FSM: IDLE → HDR0 → HDR1 → HDR2 → DATA → DONE → IDLE.
- IDLE, request accepted: reject if rows=0, cols=0, rows*cols > BLOCK_SIZE-3 (16-bit product), or matrix_id ≥ NUM_SLOTS. Rejection pulses write_error the next cycle and stays in IDLE, slot_valid unchanged. Otherwise latch inputs, clear slot_valid[id], go to HDR0.
- HDR0..2: write one header word each.
- DATA: each data_valid writes base+3+count and increments count. The beat at count = rows*cols-1 moves the FSM to DONE.
- DONE: write_done=1, set slot_valid[id], return to IDLE.
- write_request outside IDLE and data_valid outside DATA are ignored.
- Port ownership: the writer owns the BRAM in HDR0..2 and in DATA cycles with data_valid=1. Otherwise the arbiter grants the lowest-index requester at or after the rotating pointer. The pointer then moves to granted+1 mod NUM_READERS.
- Clear: slot_valid[clear_id] drops the next cycle. A clear aimed at the slot currently being written (HDR0..DONE) is ignored. A clear and a DONE on different slots in the same cycle both take effect.

## Timing
- Reset: write_ready=1, writer_ready=0, write_done=0, write_error=0, slot_valid=0, rd_valid=0, rd_data=0, FSM=IDLE, arbiter pointer=0, counters 0.
- Reset mid-operation aborts the write and invalidates all slots; BRAM contents are not cleared.
- Accept at cycle T: HDR0 at T+1, DATA (writer_ready=1) at T+4. write_done fires the cycle after the last beat.
- 2×3 write with continuous data_valid: accept to write_done = 10 cycles.
- Read latency: grant at cycle G, rd_valid[i] and rd_data at G+1. A single reader with continuous requests gets one word per cycle.
- rd_grant=0 for all readers in writer-owned cycles; pending requests keep their position.

## Test plan
- Write id=2, 2×3, name "MATA    ", data 1..6 → addr 2304=0x00000203, 2305=0x4D415441, 2306=0x20202020, 2307..2312=1..6; write_done one cycle after the 6th beat; slot_valid=0x04.
- Request 40×40 (1600 > 1149), then rows=0 → write_error pulses each time; slot_valid unchanged; write_ready stays 1.
- Both readers request continuously with idle writer → grants alternate R0,R1,R0,…; each rd_valid one cycle after its grant with correct data.
- Reader 0 requests during DATA with data_valid=1,1,0,1 → grant only in the data_valid=0 cycle; data returns next cycle.
- clear_req id=2 after first test → slot_valid=0x00 next cycle. Clear id=5 during a write to slot 5 → ignored; slot_valid[5]=1 after DONE.
- Assert rst_n=0 mid-DATA → writer_ready=0, slot_valid=0 immediately. After release, a full write to id=0 completes normally.

Source files
------------

// File: rtl/matrix_bank_manager_if.sv
// Bus bundle for matrix_bank_manager: write engine, slot control and read ports.
//
// Handshake rules:
//   - A write is accepted on a clock edge where write_request=1 and write_ready=1.
//     write_request while write_ready=0 is ignored.
//   - An element is consumed on a clock edge where data_valid=1 and writer_ready=1.
//     data_valid while writer_ready=0 is ignored.
//   - A read is taken on a clock edge where rd_req[i]=1 and rd_grant[i]=1; the
//     requester holds rd_req[i] and its rd_addr slice stable until that edge.
//     rd_valid[i] with rd_data follows one cycle later.
interface matrix_bank_manager_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_READERS = 2
);
  localparam int ID_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                            write_request;
  logic                            write_ready;
  logic [ID_W-1:0]                 matrix_id;
  logic [7:0]                      actual_rows;
  logic [7:0]                      actual_cols;
  logic [7:0]                      matrix_name [0:7];
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            data_valid;
  logic                            writer_ready;
  logic                            write_done;
  logic                            write_error;
  logic                            clear_req;
  logic [ID_W-1:0]                 clear_id;
  logic [NUM_SLOTS-1:0]            slot_valid;
  logic [NUM_READERS-1:0]          rd_req;
  logic [NUM_READERS*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READERS-1:0]          rd_grant;
  logic [NUM_READERS-1:0]          rd_valid;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic [2:0]                      fsm_state;   // write FSM state, for observation

  modport master (
    output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid, clear_req, clear_id, rd_req, rd_addr,
    input  write_ready, writer_ready, write_done, write_error, slot_valid,
           rd_grant, rd_valid, rd_data, fsm_state
  );

  modport slave (
    input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid, clear_req, clear_id, rd_req, rd_addr,
    output write_ready, writer_ready, write_done, write_error, slot_valid,
           rd_grant, rd_valid, rd_data, fsm_state
  );
endinterface

// File: rtl/matrix_bank_manager.sv
// Slot-organised matrix store: one single-port BRAM split into NUM_SLOTS blocks,
// a header/data write engine and round-robin arbitrated read ports.
module matrix_bank_manager #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int BLOCK_SIZE  = 1152,
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_READERS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  matrix_bank_manager_if.slave bus
);
  localparam int ID_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int RIW  = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR0 = 3'd1, S_HDR1 = 3'd2, S_HDR2 = 3'd3,
    S_DATA = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [7:0]             rows_q, rows_d, cols_q, cols_d;
  logic [7:0]             name_q [0:7];
  logic [7:0]             name_d [0:7];
  logic [15:0]            total_q, total_d, count_q, count_d;
  logic                   err_q, err_d;
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [RIW-1:0]         ptr_q, ptr_d;
  logic [NUM_READERS-1:0] rd_valid_q;
  logic [DATA_WIDTH-1:0]  mem_q;

  logic [15:0]            prod;
  logic                   reject, accept_ok;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [NUM_READERS-1:0] grant;
  logic [RIW-1:0]         gidx, cand;
  logic                   found;
  logic [ADDR_WIDTH-1:0]  rd_a;

  logic [DATA_WIDTH-1:0]  mem [0:(2**ADDR_WIDTH)-1];

  // Request validation happens on the raw inputs in IDLE.
  assign prod      = 16'(bus.actual_rows) * 16'(bus.actual_cols);
  assign reject    = (bus.actual_rows == 8'd0) || (bus.actual_cols == 8'd0) ||
                     (prod > 16'(BLOCK_SIZE - 3)) || (32'(bus.matrix_id) >= NUM_SLOTS);
  assign accept_ok = (state_q == S_IDLE) && bus.write_request && !reject;

  // Write FSM: next state, latched request fields and the BRAM write port.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    base_d  = base_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    name_d  = name_q;
    total_d = total_q;
    count_d = count_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = base_q;
    wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.write_request) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            id_d    = bus.matrix_id;
            base_d  = ADDR_WIDTH'(32'(bus.matrix_id) * BLOCK_SIZE);
            rows_d  = bus.actual_rows;
            cols_d  = bus.actual_cols;
            for (int i = 0; i < 8; i++) name_d[i] = bus.matrix_name[i];
            total_d = prod;
            count_d = 16'd0;
            state_d = S_HDR0;
          end
        end
      end
      S_HDR0: begin
        wr_en   = 1'b1;
        wr_addr = base_q;
        wr_data = DATA_WIDTH'({rows_q, cols_q});
        state_d = S_HDR1;
      end
      S_HDR1: begin
        wr_en   = 1'b1;
        wr_addr = base_q + ADDR_WIDTH'(1);
        wr_data = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
        state_d = S_HDR2;
      end
      S_HDR2: begin
        wr_en   = 1'b1;
        wr_addr = base_q + ADDR_WIDTH'(2);
        wr_data = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
        state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.data_valid) begin
          wr_en   = 1'b1;
          wr_addr = base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(count_q);
          wr_data = bus.data_in;
          count_d = count_q + 16'd1;
          if (count_q == total_q - 16'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slot bitmap: accept clears, completion sets, clear_req invalidates unless busy on it.
  always_comb begin
    valid_d = valid_q;
    if (accept_ok) valid_d[bus.matrix_id] = 1'b0;
    if (state_q == S_DONE) valid_d[id_q] = 1'b1;
    if (bus.clear_req && (32'(bus.clear_id) < NUM_SLOTS) &&
        !((state_q != S_IDLE) && (bus.clear_id == id_q)))
      valid_d[bus.clear_id] = 1'b0;
  end

  // Round-robin arbiter; the writer pre-empts all readers whenever it writes.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_READERS; i++) begin
      cand = RIW'((int'(ptr_q) + i) % NUM_READERS);
      if (!found && !wr_en && bus.rd_req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    if (found) grant[gidx] = 1'b1;
    ptr_d = ptr_q;
    if (found) ptr_d = (gidx == RIW'(NUM_READERS - 1)) ? '0 : gidx + RIW'(1);
  end

  assign rd_a = bus.rd_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];

  // Single-port BRAM: write has priority, otherwise one granted read per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (found) mem_q <= mem[rd_a];
  end

  // Control and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      base_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      name_q     <= '{default: 8'h00};
      total_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= '0;
      ptr_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      name_q     <= name_d;
      total_q    <= total_d;
      count_q    <= count_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= grant;
    end
  end

  assign bus.write_ready  = (state_q == S_IDLE);
  assign bus.writer_ready = (state_q == S_DATA);
  assign bus.write_done   = (state_q == S_DONE);
  assign bus.write_error  = err_q;
  assign bus.slot_valid   = valid_q;
  assign bus.rd_grant     = grant;
  assign bus.rd_valid     = rd_valid_q;
  // Read data is forced to zero when no reader is being served (reset-clean output).
  assign bus.rd_data      = (|rd_valid_q) ? mem_q : '0;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_matrix_bank_manager.sv
// Self-checking bench for matrix_bank_manager.
module tb_matrix_bank_manager;
  localparam int DW = 32, AW = 14, BS = 1152, NS = 8, NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_bank_manager_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLOTS(NS),
                           .NUM_READERS(NR)) ifc ();

  matrix_bank_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
                        .NUM_SLOTS(NS), .NUM_READERS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: expected read data and reader index, in grant order.
  logic [DW-1:0] exp_q[$];
  int            exp_r_q[$];
  logic [DW-1:0] mon_e;
  int            mon_r;
  logic [NR-1:0] mon_oh;

  always @(negedge clk) begin
    if (rst_n && ifc.rd_valid !== '0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected rd_valid=%b rd_data=%h", ifc.rd_valid, ifc.rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_r = exp_r_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_r] = 1'b1;
        if (ifc.rd_valid !== mon_oh || ifc.rd_data !== mon_e) begin
          miscompares++;
          $display("FAIL rd_data got valid=%b data=%h exp valid=%b data=%h",
                   ifc.rd_valid, ifc.rd_data, mon_oh, mon_e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    ifc.write_request = 1'b0;
    ifc.matrix_id     = '0;
    ifc.actual_rows   = '0;
    ifc.actual_cols   = '0;
    for (int i = 0; i < 8; i++) ifc.matrix_name[i] = 8'h20;
    ifc.data_in       = '0;
    ifc.data_valid    = 1'b0;
    ifc.clear_req     = 1'b0;
    ifc.clear_id      = '0;
    ifc.rd_req        = '0;
    ifc.rd_addr       = '0;
  endtask

  // Issue a one-cycle request and wait until DATA; checks the 3-cycle header phase.
  task automatic start_write(input logic [2:0] id, input logic [7:0] rows,
                             input logic [7:0] cols, input logic [63:0] nm);
    int n;
    n = 0;
    ifc.matrix_id   = id;
    ifc.actual_rows = rows;
    ifc.actual_cols = cols;
    for (int i = 0; i < 8; i++) ifc.matrix_name[i] = nm[63-8*i -: 8];
    ifc.write_request = 1'b1;
    tick();
    ifc.write_request = 1'b0;
    while (ifc.writer_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL hdr_latency got %0d cycles exp 3", n);
    end
  endtask

  // Read one word; expected value is queued for the monitor.
  task automatic rd_one(input int r, input logic [AW-1:0] a, input logic [DW-1:0] e);
    int n;
    n = 0;
    ifc.rd_req[r] = 1'b1;
    ifc.rd_addr[r*AW +: AW] = a;
    exp_q.push_back(e);
    exp_r_q.push_back(r);
    @(negedge clk);
    while (ifc.rd_grant[r] !== 1'b1 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_grant_timeout reader=%0d addr=%0d", r, a);
      void'(exp_q.pop_back());
      void'(exp_r_q.pop_back());
    end
    tick();
    ifc.rd_req[r] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    init_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if (ifc.write_ready !== 1'b1 || ifc.writer_ready !== 1'b0 || ifc.write_done !== 1'b0 ||
        ifc.write_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got wr_rdy=%b wrt_rdy=%b done=%b err=%b exp 1 0 0 0",
               ifc.write_ready, ifc.writer_ready, ifc.write_done, ifc.write_error);
    end
    vectors++;
    if (ifc.slot_valid !== 8'h00 || ifc.rd_valid !== 2'b00 || ifc.rd_data !== 32'h0 ||
        ifc.fsm_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data got slot=%h rdv=%b rdd=%h st=%0d exp 0 0 0 0",
               ifc.slot_valid, ifc.rd_valid, ifc.rd_data, ifc.fsm_state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    start_write(3'd2, 8'd2, 8'd3, 64'h4D41544120202020);
    for (int k = 0; k < 6; k++) begin
      ifc.data_valid = 1'b1;
      ifc.data_in = 32'(k + 1);
      @(negedge clk);
      vectors++;
      if (ifc.write_done !== 1'b0) begin
        miscompares++;
        $display("FAIL early_done beat=%0d got %b exp 0", k, ifc.write_done);
      end
      tick();
    end
    ifc.data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.write_done !== 1'b1) begin
      miscompares++;
      $display("FAIL write_done got %b exp 1", ifc.write_done);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ifc.write_done !== 1'b0 || ifc.slot_valid !== 8'h04) begin
      miscompares++;
      $display("FAIL after_done got done=%b slot=%h exp 0 04", ifc.write_done, ifc.slot_valid);
    end
    tick();
    rd_one(0, 14'd2304, 32'h00000203);
    rd_one(0, 14'd2305, 32'h4D415441);
    rd_one(0, 14'd2306, 32'h20202020);
    for (int k = 0; k < 6; k++) rd_one(0, AW'(2307 + k), 32'(k + 1));
    repeat (2) tick();
  endtask

  task automatic test_reject();
    logic [7:0] rows_t [3];
    logic [7:0] cols_t [3];
    rows_t = '{8'd40, 8'd0, 8'd46};
    cols_t = '{8'd40, 8'd5, 8'd25};
    for (int t = 0; t < 3; t++) begin
      ifc.matrix_id = 3'd3;
      ifc.actual_rows = rows_t[t];
      ifc.actual_cols = cols_t[t];
      ifc.write_request = 1'b1;
      tick();
      ifc.write_request = 1'b0;
      @(negedge clk);
      vectors++;
      if (ifc.write_error !== 1'b1 || ifc.write_ready !== 1'b1 || ifc.slot_valid !== 8'h04) begin
        miscompares++;
        $display("FAIL reject_%0d got err=%b rdy=%b slot=%h exp 1 1 04",
                 t, ifc.write_error, ifc.write_ready, ifc.slot_valid);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (ifc.write_error !== 1'b0 || ifc.writer_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reject_pulse_%0d got err=%b wrt_rdy=%b exp 0 0",
                 t, ifc.write_error, ifc.writer_ready);
      end
      tick();
    end
  endtask

  task automatic test_arbiter();
    logic [NR-1:0] exp_g;
    // A lone reader-1 read leaves the rotating pointer at reader 0.
    rd_one(1, 14'd2308, 32'd2);
    ifc.rd_addr = {AW'(2308), AW'(2307)};
    ifc.rd_req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (ifc.rd_grant !== exp_g) begin
        miscompares++;
        $display("FAIL arb_grant_%0d got %b exp %b", k, ifc.rd_grant, exp_g);
      end
      exp_q.push_back((k % 2 == 0) ? 32'd1 : 32'd2);
      exp_r_q.push_back(k % 2);
      tick();
    end
    ifc.rd_req = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_clear();
    ifc.clear_req = 1'b1;
    ifc.clear_id = 3'd2;
    @(negedge clk);
    vectors++;
    if (ifc.slot_valid !== 8'h04) begin
      miscompares++;
      $display("FAIL clear_early got %h exp 04", ifc.slot_valid);
    end
    tick();
    ifc.clear_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.slot_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL clear_slot got %h exp 00", ifc.slot_valid);
    end
    tick();
  endtask

  task automatic test_writer_priority();
    start_write(3'd5, 8'd2, 8'd2, 64'h534C4F5435202020);
    ifc.data_valid = 1'b1;
    ifc.data_in = 32'hA0;
    ifc.rd_req[0] = 1'b1;
    ifc.rd_addr[0 +: AW] = 14'd2307;
    ifc.clear_req = 1'b1;
    ifc.clear_id = 3'd5;
    @(negedge clk);
    vectors++;
    if (ifc.rd_grant !== 2'b00) begin
      miscompares++;
      $display("FAIL prio_beat0 got %b exp 00", ifc.rd_grant);
    end
    tick();
    ifc.clear_req = 1'b0;
    ifc.data_in = 32'hA1;
    @(negedge clk);
    vectors++;
    if (ifc.rd_grant !== 2'b00) begin
      miscompares++;
      $display("FAIL prio_beat1 got %b exp 00", ifc.rd_grant);
    end
    tick();
    ifc.data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.rd_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL prio_gap got %b exp 01", ifc.rd_grant);
    end
    exp_q.push_back(32'd1);
    exp_r_q.push_back(0);
    tick();
    ifc.rd_req[0] = 1'b0;
    ifc.data_valid = 1'b1;
    ifc.data_in = 32'hA2;
    tick();
    ifc.data_in = 32'hA3;
    tick();
    ifc.data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.write_done !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_done got %b exp 1", ifc.write_done);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ifc.slot_valid !== 8'h20) begin
      miscompares++;
      $display("FAIL clear_ignored got %h exp 20", ifc.slot_valid);
    end
    tick();
    rd_one(0, 14'd5760, 32'h00000202);
    rd_one(0, 14'd5761, 32'h534C4F54);
    rd_one(1, 14'd5765, 32'hA2);
    rd_one(0, 14'd5766, 32'hA3);
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    start_write(3'd3, 8'd2, 8'd2, 64'h4D49442020202020);
    ifc.data_valid = 1'b1;
    ifc.data_in = 32'h55;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ifc.writer_ready !== 1'b0 || ifc.slot_valid !== 8'h00 || ifc.write_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid got wrt_rdy=%b slot=%h wr_rdy=%b exp 0 00 1",
               ifc.writer_ready, ifc.slot_valid, ifc.write_ready);
    end
    ifc.data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_write(3'd0, 8'd1, 8'd3, 64'h5A45524F20202020);
    for (int k = 0; k < 3; k++) begin
      ifc.data_valid = 1'b1;
      ifc.data_in = 32'(7 + k);
      tick();
    end
    ifc.data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.write_done !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_done got %b exp 1", ifc.write_done);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ifc.slot_valid !== 8'h01) begin
      miscompares++;
      $display("FAIL post_reset_slot got %h exp 01", ifc.slot_valid);
    end
    tick();
    rd_one(0, 14'd0, 32'h00000103);
    rd_one(1, 14'd1, 32'h5A45524F);
    for (int k = 0; k < 3; k++) rd_one(k % 2, AW'(3 + k), 32'(7 + k));
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_reject();
    test_arbiter();
    test_clear();
    test_writer_priority();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
